board_status_ctrl: RTL and testbench
====================================

Name: board_status_ctrl

Overview:
- Board-level reset sequencer and LED status driver for the top-level shell.
- Qualifies PLL lock and holds the system reset for a programmable time before release.
- Handles software reset requests.
- Drives the LED bank with a run pattern, heartbeat and kernel-activity indication.
- Parametrised in LED count, hold times and heartbeat rate.

Parameters:
- NUM_LEDS, 8: LED bank width; must be >= 3.
- RESET_HOLD_CYCLES, 1024: consecutive cycles of qualified lock before reset release; must be >= 2.
- SW_RESET_CYCLES, 64: cycles system_resetn is held low after a software reset request; must be >= 1.
- HEARTBEAT_DIV_LOG2, 26: heartbeat counter width; the LED toggles every 2^(HEARTBEAT_DIV_LOG2-1) cycles.
- IDLE_PATTERN, 8'h28: static pattern for leds[NUM_LEDS-3:0] in RUN; zero-extended or truncated to NUM_LEDS-2 bits.
- STRETCH_CYCLES, 4096: minimum on-time of the activity LED. Used only with the optional feature.

Ports:
- config_clk, in, 1: 100 MHz configuration clock; the only clock.
- resetn, in, 1: asynchronous active-low reset.
- pll_locked, in, 1: kernel PLL lock, asynchronous.
- ext_reset_req, in, 1: software reset request, asynchronous, level. Its rising edge is the trigger.
- kernel_busy, in, 1: kernel activity, asynchronous.
- system_resetn, out, 1: registered active-low reset to the system.
- reset_done, out, 1: high while in RUN.
- relock_count, out, 8: saturating count of lock losses seen in RUN.
- leds, out, NUM_LEDS: registered LED drive.

Behaviour:
- Reset values: system_resetn=0, reset_done=0, relock_count=0, leds=0.
- Reset effects:
  - Async assertion of resetn forces state HOLD and clears all counters and sync flops.
  - Mid-operation reset behaves identically.
- Input synchronisation:
  - pll_locked, ext_reset_req and kernel_busy each pass through a 2-flop synchroniser (2-cycle latency); the results are lock_s, req_s and busy_s.
  - req_s is edge-detected with one extra flop: req_rise = req_s & ~req_q.
- States: HOLD, RUN, SWRST.
- HOLD:
  - Counter hold_cnt increments each cycle lock_s=1. If lock_s=0, hold_cnt clears.
  - When hold_cnt==RESET_HOLD_CYCLES-1 and lock_s=1, go to RUN.
  - Net effect: system_resetn rises on the clock edge ending the RESET_HOLD_CYCLES-th consecutive lock_s=1 cycle.
  - req_rise is ignored.
- RUN:
  - lock_s=0: go to HOLD, clear hold_cnt, relock_count += 1 (saturates at 255).
  - Else req_rise=1: go to SWRST.
  - Lock loss has priority over a simultaneous req_rise.
- SWRST:
  - sw_cnt counts SW_RESET_CYCLES cycles, then the FSM goes to HOLD and the lock is re-qualified.
  - Lock loss in SWRST is not counted in relock_count; the hold-count logic handles it.
- Outputs, all registered from the next state, so they change on the same edge as the state:
  - system_resetn=1 and reset_done=1 only in RUN.
- Heartbeat counter:
  - Free-running, HEARTBEAT_DIV_LOG2 bits, wraps.
  - Runs in every state; cleared only by resetn.
- LEDs:
  - HOLD: all 0.
  - SWRST: all 1.
  - RUN: leds[NUM_LEDS-1] = heartbeat MSB, leds[NUM_LEDS-2] = busy_s, leds[NUM_LEDS-3:0] = IDLE_PATTERN.

Optional Feature:
- Macro BOARD_STATUS_LED_STRETCH_EN.
- Defined:
  - A busy_s rising edge loads a stretch counter with STRETCH_CYCLES-1.
  - leds[NUM_LEDS-2] = busy_s OR (counter != 0). The counter decrements to 0.
  - A re-trigger reloads the counter.
  - The counter clears on leaving RUN.
- Undefined: leds[NUM_LEDS-2] = busy_s directly, and no stretch counter exists.

Decomposition:
- Package board_status_pkg:
  - state enum (HOLD, RUN, SWRST);
  - SYNC_STAGES=2;
  - RELOCK_W=8.
- One sub-module board_sync_2ff:
  - single-bit 2-flop synchroniser with async active-low clear;
  - instantiated three times.

Test Plan (RESET_HOLD_CYCLES=16, SW_RESET_CYCLES=4, HEARTBEAT_DIV_LOG2=4, NUM_LEDS=8):
- Power-up:
  - Stimulus: resetn deasserts, pll_locked=1 held.
  - Required: system_resetn rises 18 cycles after the first edge sampling pll_locked=1 (2 sync + 16 hold). leds become {hb,busy,6'b101000}.
- Lock glitch in HOLD:
  - Stimulus: pll_locked drops for 1 cycle at hold count 10.
  - Required: count restarts, system_resetn stays 0 for a further full 16 cycles, relock_count=0.
- Lock loss in RUN:
  - Stimulus: three separate drops.
  - Required: relock_count=3, system_resetn low 2 cycles after each drop, leds=0 during HOLD.
  - Additionally, force 256 drops: relock_count=255.
- Software reset:
  - Stimulus: ext_reset_req rises in RUN.
  - Required: system_resetn low for 4 cycles in SWRST (leds=8'hFF), then HOLD for 16 cycles, then RUN.
  - Holding req high causes no second trigger.
- Priority:
  - Stimulus: lock drop and req rise synchronised to the same cycle.
  - Required: FSM enters HOLD, not SWRST; relock_count increments.
- Heartbeat / stretch:
  - Heartbeat: in RUN, leds[7] toggles every 8 cycles.
  - With BOARD_STATUS_LED_STRETCH_EN and STRETCH_CYCLES=32: a 1-cycle kernel_busy pulse gives leds[6] high for >= 32 cycles.
  - Without the macro: the same pulse gives leds[6] high for exactly 1 cycle.

Source files
------------

// File: rtl/board_status_pkg.sv
// Shared types and constants for the board status controller.
//   state_e     : sequencer states (HOLD, RUN, SWRST)
//   SYNC_STAGES : depth of the input synchronisers
//   RELOCK_W    : width of the saturating lock-loss counter
//   sat_inc     : saturating increment for the lock-loss counter
package board_status_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    SWRST = 2'd2
  } state_e;

  localparam int SYNC_STAGES = 2;
  localparam int RELOCK_W    = 8;

  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/board_sync_2ff.sv
// Single-bit multi-flop synchroniser with asynchronous active-low clear.
//   clk_i  : destination clock
//   rst_ni : async active-low clear, forces output low
//   d_i    : asynchronous input
//   q_o    : synchronised output (SYNC_STAGES cycles of latency)
module board_sync_2ff
  import board_status_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/board_status_ctrl.sv
// Board reset sequencer and LED status driver.
// Qualifies PLL lock for RESET_HOLD_CYCLES before releasing system reset,
// services software reset requests, counts lock losses seen while running
// and drives the LED bank (run pattern, heartbeat, kernel activity).
//   config_clk    : only clock
//   resetn        : async active-low reset
//   pll_locked    : PLL lock (async)
//   ext_reset_req : software reset request, rising edge triggers (async)
//   kernel_busy   : kernel activity (async)
//   system_resetn : registered active-low system reset, high only in RUN
//   reset_done    : high only in RUN
//   relock_count  : saturating count of lock losses while in RUN
//   leds          : registered LED drive
// Optional feature macro: BOARD_STATUS_LED_STRETCH_EN stretches the activity
// LED to at least STRETCH_CYCLES after each busy rising edge.
module board_status_ctrl
  import board_status_pkg::*;
#(
  parameter int          NUM_LEDS           = 8,
  parameter int          RESET_HOLD_CYCLES  = 1024,
  parameter int          SW_RESET_CYCLES    = 64,
  parameter int          HEARTBEAT_DIV_LOG2 = 26,
  parameter logic [63:0] IDLE_PATTERN       = 64'h28,
  parameter int          STRETCH_CYCLES     = 4096
) (
  input  logic                config_clk,
  input  logic                resetn,
  input  logic                pll_locked,
  input  logic                ext_reset_req,
  input  logic                kernel_busy,
  output logic                system_resetn,
  output logic                reset_done,
  output logic [RELOCK_W-1:0] relock_count,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES);
  localparam int SW_W   = $clog2(SW_RESET_CYCLES + 1);
  localparam int PAT_W  = NUM_LEDS - 2;
  localparam int HB_W   = HEARTBEAT_DIV_LOG2;
  localparam logic [PAT_W-1:0] IDLE_BITS = PAT_W'(IDLE_PATTERN);

  // ---- input synchronisers: [0]=lock, [1]=req, [2]=busy
  logic [2:0] async_in, sync_s;
  logic       lock_s, req_s, busy_s;

  assign async_in = {kernel_busy, ext_reset_req, pll_locked};

  board_sync_2ff u_sync [2:0] (
    .clk_i  (config_clk),
    .rst_ni (resetn),
    .d_i    (async_in),
    .q_o    (sync_s)
  );

  assign lock_s = sync_s[0];
  assign req_s  = sync_s[1];
  assign busy_s = sync_s[2];

  // ---- state
  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [SW_W-1:0]     sw_cnt_q, sw_cnt_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic [HB_W-1:0]     hb_q, hb_d;
  logic                req_q, req_rise;
  logic                act_led;
  logic [NUM_LEDS-1:0] leds_d;

  assign req_rise = req_s & ~req_q;
  assign hb_d     = hb_q + 1'b1;

  // Counters default to zero so each one is clear whenever its state is left.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    sw_cnt_d   = '0;
    relock_d   = relock_q;
    case (state_q)
      HOLD: begin
        if (lock_s) begin
          if (hold_cnt_q == HOLD_W'(RESET_HOLD_CYCLES - 1)) state_d = RUN;
          else hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        // lock loss wins over a simultaneous request edge
        if (!lock_s) begin
          state_d  = HOLD;
          relock_d = sat_inc(relock_q);
        end else if (req_rise) begin
          state_d = SWRST;
        end
      end
      SWRST: begin
        if (sw_cnt_q == SW_W'(SW_RESET_CYCLES - 1)) state_d = HOLD;
        else sw_cnt_d = sw_cnt_q + 1'b1;
      end
      default: state_d = HOLD;
    endcase
  end

`ifdef BOARD_STATUS_LED_STRETCH_EN
  localparam int STR_W = $clog2(STRETCH_CYCLES + 1);
  logic             busy_q;
  logic [STR_W-1:0] str_q, str_d;

  always_comb begin
    str_d = str_q;
    if (state_d != RUN)         str_d = '0;
    else if (busy_s && !busy_q) str_d = STR_W'(STRETCH_CYCLES - 1);
    else if (str_q != '0)       str_d = str_q - 1'b1;
  end

  always_ff @(posedge config_clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      str_q  <= '0;
    end else begin
      busy_q <= busy_s;
      str_q  <= str_d;
    end
  end

  assign act_led = busy_s | (str_q != '0);
`else
  logic unused_stretch;
  assign unused_stretch = |STRETCH_CYCLES;
  assign act_led        = busy_s;
`endif

  // LEDs follow the next state so they switch on the same edge as the FSM.
  always_comb begin
    case (state_d)
      RUN:     leds_d = {hb_d[HB_W-1], act_led, IDLE_BITS};
      SWRST:   leds_d = '1;
      default: leds_d = '0;
    endcase
  end

  always_ff @(posedge config_clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= HOLD;
      hold_cnt_q    <= '0;
      sw_cnt_q      <= '0;
      relock_q      <= '0;
      hb_q          <= '0;
      req_q         <= 1'b0;
      system_resetn <= 1'b0;
      reset_done    <= 1'b0;
      leds          <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      sw_cnt_q      <= sw_cnt_d;
      relock_q      <= relock_d;
      hb_q          <= hb_d;
      req_q         <= req_s;
      system_resetn <= (state_d == RUN);
      reset_done    <= (state_d == RUN);
      leds          <= leds_d;
    end
  end

  assign relock_count = relock_q;

endmodule

// File: tb/tb_board_status_ctrl.sv
// Directed bench for board_status_ctrl with short hold/heartbeat settings.
module tb_board_status_ctrl;

  logic       config_clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_locked = 1'b0;
  logic       ext_reset_req = 1'b0;
  logic       kernel_busy = 1'b0;
  logic       system_resetn, reset_done;
  logic [7:0] relock_count;
  logic [7:0] leds;

  int checks = 0;
  int errors = 0;

  board_status_ctrl #(
    .NUM_LEDS(8), .RESET_HOLD_CYCLES(16), .SW_RESET_CYCLES(4),
    .HEARTBEAT_DIV_LOG2(4), .IDLE_PATTERN(64'h28), .STRETCH_CYCLES(32)
  ) dut (
    .config_clk    (config_clk),
    .resetn        (resetn),
    .pll_locked    (pll_locked),
    .ext_reset_req (ext_reset_req),
    .kernel_busy   (kernel_busy),
    .system_resetn (system_resetn),
    .reset_done    (reset_done),
    .relock_count  (relock_count),
    .leds          (leds)
  );

  always #5 config_clk = ~config_clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge config_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic prev, exp_b, found, stable;
    int   cnt;

    // ---- reset state
    step(3);
    chk("rst_sysrstn", system_resetn, 0);
    chk("rst_done", reset_done, 0);
    chk("rst_relock", relock_count, 0);
    chk("rst_leds", leds, 0);

    // ---- power-up with a 1-cycle lock glitch at hold count 10
    resetn = 1'b1;
    step(2);
    pll_locked = 1'b1;          // E1 is the next edge
    step(10);
    pll_locked = 1'b0;          // sampled at E11 only
    step(1);
    pll_locked = 1'b1;
    step(1);                    // after E12: hold count is 10
    chk("glitch_hold_e12", system_resetn, 0);
    step(16);                   // after E28
    chk("glitch_low_e28", system_resetn, 0);
    chk("glitch_leds_hold", leds, 0);
    step(1);                    // after E29: 16th qualified cycle done
    chk("glitch_high_e29", system_resetn, 1);
    chk("glitch_done", reset_done, 1);
    chk("glitch_relock0", relock_count, 0);
    chk("run_pattern", leds[6:0], 7'h28);

    // ---- heartbeat period
    prev = leds[7];
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (leds[7] !== prev) found = 1'b1;
    end
    chk("hb_toggle_seen", found, 1);
    prev = leds[7];
    stable = 1'b1;
    repeat (7) begin
      step(1);
      if (leds[7] !== prev) stable = 1'b0;
    end
    chk("hb_stable_7", stable, 1);
    step(1);
    exp_b = ~prev;
    chk("hb_toggle_8", leds[7], exp_b);

    // ---- activity LED from a 1-cycle busy pulse
    kernel_busy = 1'b1;
    step(1);
    kernel_busy = 1'b0;
    cnt = 0;
    repeat (60) begin
      step(1);
      if (leds[6] === 1'b1) cnt++;
    end
`ifdef BOARD_STATUS_LED_STRETCH_EN
    chk("busy_stretch_ge32", (cnt >= 32), 1);
`else
    chk("busy_pulse_1", cnt, 1);
`endif

    // ---- three lock losses in RUN
    for (int i = 0; i < 3; i++) begin
      pll_locked = 1'b0;
      step(2);
      chk("drop_still_run", system_resetn, 1);
      step(1);
      chk("drop_sysrstn_low", system_resetn, 0);
      chk("drop_leds0", leds, 0);
      pll_locked = 1'b1;
      step(18);
      chk("drop_rerun", system_resetn, 1);
    end
    chk("relock_3", relock_count, 3);

    // ---- software reset
    ext_reset_req = 1'b1;
    step(2);
    chk("sw_before", system_resetn, 1);
    step(1);
    chk("sw_enter_low", system_resetn, 0);
    chk("sw_leds_ff", leds, 8'hFF);
    step(3);
    chk("sw_last_ff", leds, 8'hFF);
    step(1);
    chk("sw_hold_leds0", leds, 0);
    chk("sw_hold_low", system_resetn, 0);
    step(15);
    chk("sw_hold_end_low", system_resetn, 0);
    step(1);
    chk("sw_run", system_resetn, 1);
    step(10);
    chk("sw_no_retrigger", system_resetn, 1);
    chk("sw_relock_same", relock_count, 3);
    ext_reset_req = 1'b0;
    step(4);

    // ---- lock loss and request edge on the same cycle
    pll_locked = 1'b0;
    ext_reset_req = 1'b1;
    step(3);
    chk("prio_low", system_resetn, 0);
    chk("prio_leds_hold", leds, 0);
    chk("prio_relock", relock_count, 4);
    step(1);
    chk("prio_still_hold", leds, 0);
    pll_locked = 1'b1;
    step(18);
    chk("prio_rerun", system_resetn, 1);
    ext_reset_req = 1'b0;
    step(4);

    // ---- relock saturation
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b0;
      step(3);
      pll_locked = 1'b1;
      step(18);
    end
    chk("relock_sat", relock_count, 255);
    chk("sat_run", system_resetn, 1);

    // ---- mid-operation async reset, then clean power-up with lock held
    resetn = 1'b0;
    #1;
    chk("mid_rst_sysrstn", system_resetn, 0);
    chk("mid_rst_relock", relock_count, 0);
    chk("mid_rst_leds", leds, 0);
    step(2);
    resetn = 1'b1;              // lock already high: E1 is the next edge
    step(17);
    chk("pu_low_e17", system_resetn, 0);
    step(1);
    chk("pu_high_e18", system_resetn, 1);
    chk("pu_done", reset_done, 1);
    chk("pu_leds", leds[6:0], 7'h28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
